// File: rtl/reflex_ctrl.sv
// rtl/reflex_ctrl.sv - reaction-time tester sequencer: random delay, stimulus LED, reaction timing
// Owns the 1 ms tick generator through clear_ms; flags in RESULT are mutually exclusive.
module reflex_ctrl #(
  parameter int          MIN_DELAY_MS = 1000,
  parameter int          MAX_REACT_MS = 9999,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
  input  logic        ck,
  input  logic        reset,
  input  logic        start,
  input  logic        stop,
  input  logic        one_ms,
  output logic        clear_ms,
  output logic        led,
  output logic [13:0] time_ms,
  output logic        done,
  output logic        too_soon,
  output logic        timeout
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_REACT, S_RESULT} state_t;

  state_t      state_q, state_d;
  logic [15:0] lfsr_q, lfsr_d;
  logic [13:0] ms_cnt_q, ms_cnt_d;
  logic [10:0] delay_tgt_q, delay_tgt_d;
  logic        led_q, led_d;
  logic [13:0] time_q, time_d;
  logic        done_q, done_d;
  logic        too_soon_q, too_soon_d;
  logic        timeout_q, timeout_d;
  logic [13:0] ms_next;

  assign ms_next = ms_cnt_q + 14'd1;

  always_ff @(posedge ck or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      lfsr_q      <= LFSR_SEED;
      ms_cnt_q    <= '0;
      delay_tgt_q <= '0;
      led_q       <= 1'b0;
      time_q      <= '0;
      done_q      <= 1'b0;
      too_soon_q  <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      lfsr_q      <= lfsr_d;
      ms_cnt_q    <= ms_cnt_d;
      delay_tgt_q <= delay_tgt_d;
      led_q       <= led_d;
      time_q      <= time_d;
      done_q      <= done_d;
      too_soon_q  <= too_soon_d;
      timeout_q   <= timeout_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    lfsr_d      = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    ms_cnt_d    = ms_cnt_q;
    delay_tgt_d = delay_tgt_q;
    led_d       = led_q;
    time_d      = time_q;
    done_d      = done_q;
    too_soon_d  = too_soon_q;
    timeout_d   = timeout_q;
    clear_ms    = 1'b0;

    unique case (state_q)
      S_IDLE, S_RESULT: begin
        clear_ms = 1'b1;
        if (start) begin
          delay_tgt_d = 11'(MIN_DELAY_MS) + {1'b0, lfsr_q[9:0]};
          ms_cnt_d    = '0;
          done_d      = 1'b0;
          too_soon_d  = 1'b0;
          timeout_d   = 1'b0;
          time_d      = '0;
          led_d       = 1'b0;
          state_d     = S_WAIT;
        end
      end
      S_WAIT: begin
        if (stop) begin
          too_soon_d = 1'b1;
          time_d     = '0;
          led_d      = 1'b0;
          state_d    = S_RESULT;
        end else if (one_ms) begin
          if (ms_next == {3'b000, delay_tgt_q}) begin
            // Restart the tick generator so the first reaction ms lines up with the LED edge.
            clear_ms = 1'b1;
            ms_cnt_d = '0;
            led_d    = 1'b1;
            state_d  = S_REACT;
          end else begin
            ms_cnt_d = ms_next;
          end
        end
      end
      S_REACT: begin
        if (stop) begin
          time_d  = ms_cnt_q;
          done_d  = 1'b1;
          led_d   = 1'b0;
          state_d = S_RESULT;
        end else if (one_ms) begin
          if (ms_next == 14'(MAX_REACT_MS)) begin
            time_d    = 14'(MAX_REACT_MS);
            timeout_d = 1'b1;
            led_d     = 1'b0;
            state_d   = S_RESULT;
          end else begin
            ms_cnt_d = ms_next;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign led      = led_q;
  assign time_ms  = time_q;
  assign done     = done_q;
  assign too_soon = too_soon_q;
  assign timeout  = timeout_q;

endmodule

// File: tb/tb_reflex_ctrl.sv
// tb/tb_reflex_ctrl.sv - self-checking bench for reflex_ctrl with trial-level reference model
module tb_reflex_ctrl;

  logic        ck = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        one_ms = 1'b0;
  logic        clear_ms;
  logic        led;
  logic [13:0] time_ms;
  logic        done;
  logic        too_soon;
  logic        timeout;

  int errors = 0;
  int checks = 0;
  int gmax = 0;
  logic [15:0] m_lfsr;

  reflex_ctrl dut (
    .ck(ck), .reset(reset), .start(start), .stop(stop), .one_ms(one_ms),
    .clear_ms(clear_ms), .led(led), .time_ms(time_ms), .done(done),
    .too_soon(too_soon), .timeout(timeout)
  );

  always #5 ck = ~ck;

  // Reference LFSR: x^16+x^14+x^13+x^11+1, advancing once per clock from the seed.
  always @(posedge ck or posedge reset) begin
    if (reset) m_lfsr <= 16'hACE1;
    else       m_lfsr <= {m_lfsr[14:0], ^(m_lfsr & 16'b1011_0100_0000_0000)};
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic s, input logic st, input logic m);
    @(negedge ck);
    start = s; stop = st; one_ms = m;
  endtask

  task automatic pulse();
    drive(0, 0, 1);
    repeat ($urandom_range(0, gmax)) drive(0, 0, 0);
  endtask

  task automatic check_result(input string tag, input logic [13:0] t, input logic d,
                              input logic ts, input logic to);
    #1;
    chk({tag, "_time"}, 32'(time_ms), 32'(t));
    chk({tag, "_flags"}, {29'd0, done, too_soon, timeout}, {29'd0, d, ts, to});
    chk({tag, "_led"}, 32'(led), 32'd0);
    chk({tag, "_clr"}, 32'(clear_ms), 32'd1);
  endtask

  task automatic begin_trial(output int d);
    drive(1, 0, 0);
    d = 1000 + int'(m_lfsr[9:0]);
    drive(0, 0, 0);
    #1;
    chk("start_clears", {29'd0, done, too_soon, timeout}, 32'd0);
  endtask

  task automatic wait_to_react(input int d, input bit poke_start);
    for (int i = 1; i < d; i++) begin
      pulse();
      if (poke_start && i == d / 2) drive(1, 0, 0);
    end
    drive(0, 0, 0);
    #1;
    chk("wait_led_low", 32'(led), 32'd0);
    chk("wait_clr_low", 32'(clear_ms), 32'd0);
    drive(0, 0, 1);
    #1;
    chk("expiry_clr_high", 32'(clear_ms), 32'd1);
    drive(0, 0, 0);
    #1;
    chk("react_led_high", 32'(led), 32'd1);
    chk("react_clr_low", 32'(clear_ms), 32'd0);
  endtask

  task automatic react_stop(input int n, input bit poke_start);
    for (int i = 0; i < n; i++) begin
      pulse();
      if (poke_start && i == n / 2) drive(1, 0, 0);
    end
    drive(0, 1, 0);
    drive(0, 0, 0);
    check_result("react_stop", 14'(n), 1, 0, 0);
  endtask

  initial begin
    int d;
    int n;
    bit led_seen;

    #2 reset = 1'b1;
    #1;
    chk("reset_outs", {17'd0, led, time_ms, done, too_soon, timeout}, 32'd0);
    chk("reset_clr", 32'(clear_ms), 32'd1);
    drive(0, 0, 0);
    reset = 1'b0;
    for (int i = 0; i < 10; i++) drive(0, (i == 4), (i % 3 == 0));
    drive(0, 0, 0);
    check_result("idle_stop_ignored", 14'd0, 0, 0, 0);

    // Normal trial, with start pokes during WAIT and REACT that must be ignored
    begin_trial(d);
    wait_to_react(d, 1);
    react_stop(250, 1);

    // Early press
    begin_trial(d);
    led_seen = 0;
    for (int i = 0; i < 500; i++) begin
      pulse();
      if (led) led_seen = 1;
    end
    drive(0, 1, 0);
    drive(0, 0, 0);
    check_result("early", 14'd0, 0, 1, 0);
    chk("early_led_seen", 32'(led_seen), 32'd0);
    begin_trial(d);
    chk("restart_wait_clr", 32'(clear_ms), 32'd0);

    // Stop on the expiry pulse still counts as too soon
    for (int i = 1; i < d; i++) pulse();
    drive(0, 1, 1);
    drive(0, 0, 0);
    check_result("stop_on_expiry", 14'd0, 0, 1, 0);

    // Simultaneous stop and tick in REACT
    gmax = 1;
    begin_trial(d);
    wait_to_react(d, 0);
    for (int i = 0; i < 42; i++) pulse();
    drive(0, 1, 1);
    drive(0, 0, 0);
    check_result("stop_with_tick", 14'd42, 1, 0, 0);

    // Timeout
    gmax = 0;
    begin_trial(d);
    wait_to_react(d, 0);
    for (int i = 0; i < 9998; i++) pulse();
    drive(0, 0, 0);
    #1;
    chk("pre_timeout_led", 32'(led), 32'd1);
    drive(0, 0, 1);
    drive(0, 0, 0);
    check_result("timeout", 14'd9999, 0, 0, 1);

    // Randomised trials
    for (int t = 0; t < 3; t++) begin
      gmax = int'($urandom_range(0, 2));
      n = int'($urandom_range(0, 1500));
      begin_trial(d);
      wait_to_react(d, 0);
      react_stop(n, 0);
    end

    // Asynchronous reset while in REACT
    gmax = 0;
    begin_trial(d);
    wait_to_react(d, 0);
    for (int i = 0; i < 17; i++) pulse();
    @(negedge ck);
    #2 reset = 1'b1;
    #1;
    chk("async_reset_outs", {17'd0, led, time_ms, done, too_soon, timeout}, 32'd0);
    chk("async_reset_clr", 32'(clear_ms), 32'd1);
    drive(0, 0, 0);
    reset = 1'b0;
    repeat (5) drive(0, 0, 0);

    begin_trial(d);
    wait_to_react(d, 0);
    react_stop(7, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/reflex_ctrl.md
# reflex_ctrl

Sequencing controller for the reaction-time tester. It owns the 1 ms tick generator through `clear_ms`, counts its `one_ms` pulses, waits a pseudo-random delay, lights the stimulus LED, and measures the time until the player presses stop. It sits between the debounced button pulses and the tick generator on one side, and the display logic on the other.

## Interface
- `MIN_DELAY_MS`, 1000: minimum wait before the LED lights, in ms.
- `MAX_REACT_MS`, 9999: reaction timeout, in ms.
- `LFSR_SEED`, 16'hACE1: LFSR reset value; must be nonzero.
- `ck` input 1: system clock. All state updates on the rising edge.
- `reset` input 1: asynchronous, active-high reset.
- `start` input 1: single-cycle, debounced start pulse.
- `stop` input 1: single-cycle, debounced reaction-button pulse.
- `one_ms` input 1: single-cycle tick from the 1 ms tick generator.
- `clear_ms` output 1: combinational; holds the tick generator's count at 0.
- `led` output 1: registered stimulus LED.
- `time_ms` output 14: registered measured reaction time in ms.
- `done` output 1: registered; a valid measurement is held.
- `too_soon` output 1: registered; stop arrived before the LED lit.
- `timeout` output 1: registered; no stop within `MAX_REACT_MS`.

## Operation
- **LFSR:** 16-bit Fibonacci, polynomial x^16+x^14+x^13+x^11+1. It shifts every clock in every state.
- **Counters:**
  - `ms_cnt` is 14 bits. It increments by 1 on each `one_ms` in WAIT and REACT.
  - `delay_tgt` is 11 bits, `MIN_DELAY_MS + lfsr[9:0]`, giving a range of 1000..2023.
- **States:** IDLE, WAIT, REACT, RESULT.
- **IDLE / RESULT:**
  - On `start`: sample `lfsr[9:0]` that cycle into `delay_tgt`.
  - Clear `ms_cnt`, `done`, `too_soon`, `timeout` and `time_ms`.
  - Go to WAIT.
  - `stop` is ignored in these states.
- **WAIT:**
  - If `stop` is high: go to RESULT with `too_soon`=1 and `time_ms`=0.
  - Else, if `one_ms` is high and `ms_cnt+1 == delay_tgt`: go to REACT, set `ms_cnt`=0, `led`=1.
  - Else count.
- **REACT:**
  - If `stop` is high: go to RESULT with `time_ms`=`ms_cnt` (pre-increment value), `done`=1, `led`=0.
  - Else, if `one_ms` is high and `ms_cnt+1 == MAX_REACT_MS`: go to RESULT with `time_ms`=`MAX_REACT_MS`, `timeout`=1, `led`=0.
  - Else count.
- **`start` outside IDLE/RESULT:** ignored in WAIT and REACT.
- **`clear_ms`:** 1 in IDLE and RESULT, and in the single cycle where the WAIT→REACT transition is taken; 0 otherwise. The first REACT ms therefore starts aligned to the LED edge.
- **Priority:** `stop` beats `one_ms` in the same cycle, in both WAIT and REACT.
- **RESULT:** holds `time_ms` and the flags until the next accepted `start`.

## Timing
- **Reset values:** state IDLE, `ms_cnt`=0, `delay_tgt`=0, LFSR=`LFSR_SEED`, `led`=0, `time_ms`=0, `done`=0, `too_soon`=0, `timeout`=0. `clear_ms`=1, since it follows from IDLE.
- **Reset mid-operation:** asynchronous. Outputs return to their reset values immediately, without waiting for a clock edge.
- **`led` rise:** in REACT, `led` goes high on the same edge that registers the state change. This is 1 clock after the qualifying `one_ms` cycle.
- **Stop/timeout latency:** `stop` → `done`/`time_ms`/`led`=0 valid on the next clock edge (1-cycle latency). Timeout behaves the same way.
- **Flag exclusivity:** exactly one of `done`, `too_soon`, `timeout` is high in RESULT; all are 0 elsewhere.
- **Widths:** `time_ms` never exceeds `MAX_REACT_MS`, and 14 bits covers 9999 with no wrap. `ms_cnt` saturates by construction through the timeout transition.

## Test plan
- **Reset:** assert `reset` mid-cycle → all outputs 0 without a clock edge, `clear_ms`=1. Release, run 10 clocks → state IDLE, LFSR sequence matches the bench model from 16'hACE1.
- **Normal trial:**
  - Pulse `start`; the bench computes D = 1000 + `lfsr[9:0]`.
  - Drive D−1 `one_ms` pulses → `led`=0.
  - On the Dth pulse → `led`=1 one clock later, and `clear_ms`=1 for exactly 1 cycle.
  - Drive 250 pulses, then `stop` → `time_ms`=250, `done`=1, `led`=0.
- **Early press:** `start`, 500 `one_ms` pulses, `stop` → `too_soon`=1, `time_ms`=0, `led` never 1. A later `start` clears `too_soon`.
- **Timeout:** enter REACT, drive 9999 pulses with no stop → `timeout`=1, `time_ms`=9999, `led`=0.
- **Simultaneous events:**
  - In REACT with `ms_cnt`=42, assert `stop` and `one_ms` in the same cycle → `time_ms`=42.
  - In WAIT, assert `stop` on the delay-expiry pulse → `too_soon`=1.
- **Ignored inputs:** `start` pulses during WAIT and REACT → no change to state, `ms_cnt` or `delay_tgt`. `stop` in IDLE → no effect. `reset` during REACT → `led`=0 immediately.
